// File: rtl/usb_pkg.sv
// Shared types and CRC16 helper for the USB packet transmit path.
package usb_pkg;

  localparam logic [3:0]  PID_DATA0    = 4'b0011;
  localparam logic [3:0]  PID_DATA1    = 4'b1011;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI} tx_state_e;

  // Reflected CRC16 (LSB first), one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Running CRC16 register with a combinational look-ahead of the next value.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc_q,
  output logic [15:0] crc_next
);

  assign crc_next = crc16_byte(crc_q, din);

  always_ff @(posedge clk) begin
    if (rst || clr) crc_q <= CRC16_INIT;
    else if (en)    crc_q <= crc_next;
  end

endmodule

// File: rtl/usb_pkt_tx.sv
// Drains LEN payload bytes from a FIFO and emits PID + payload + CRC16 as a
// registered valid/ready byte stream.
module usb_pkt_tx
  import usb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       pid,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             fifo_empty,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  tx_state_e        state;
  logic [3:0]       pid_q;
  logic             len_zero;
  logic [LEN_W-1:0] len_c, rd_left, tx_left;
  logic [1:0][7:0]  sk_buf;
  logic [1:0]       sk_cnt;
  logic             rd_vld;
  logic             avail, ld, fire, last_data, pop, crc_en, crc_clr;
  logic [7:0]       head;
  logic [15:0]      crc_q, crc_next;

  assign len_c     = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign avail     = (sk_cnt != 2'd0) || rd_vld;
  assign head      = (sk_cnt != 2'd0) ? sk_buf[0] : fifo_r_data[7:0];
  assign ld        = !tx_valid || tx_ready;
  assign fire      = tx_valid && tx_ready;
  assign last_data = (tx_left == LEN_ONE);
  assign crc_en    = (state == DATA) && fire;
  assign crc_clr   = (state == IDLE) && start;

  // Reads in flight count against skid space so a returning byte always has a slot.
  assign fifo_rd_en = !fifo_empty && (rd_left != '0) &&
                      (({1'b0, sk_cnt} + {2'b00, rd_vld}) < 3'd2);

  always_comb begin
    pop = 1'b0;
    if (state == PID && fire && !len_zero)             pop = avail;
    if (state == DATA && ld && !(fire && last_data))   pop = avail;
  end

  usb_crc16 u_crc (
    .clk      (clk),
    .rst      (rst),
    .clr      (crc_clr),
    .en       (crc_en),
    .din      (tx_data),
    .crc_q    (crc_q),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pid_q    <= '0;
      len_zero <= 1'b0;
      rd_left  <= '0;
      tx_left  <= '0;
      sk_buf   <= '0;
      sk_cnt   <= 2'd0;
      rd_vld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= fifo_rd_en;
      if (fifo_rd_en) rd_left <= rd_left - LEN_ONE;

      // With an empty buffer a returning byte bypasses straight to the output.
      case ({rd_vld, pop})
        2'b10: begin
          sk_buf[sk_cnt[0]] <= fifo_r_data[7:0];
          sk_cnt            <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk_buf[0] <= sk_buf[1];
          sk_cnt    <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd2) begin
            sk_buf[0] <= sk_buf[1];
            sk_buf[1] <= fifo_r_data[7:0];
          end else if (sk_cnt == 2'd1) begin
            sk_buf[0] <= fifo_r_data[7:0];
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: if (start) begin
          pid_q    <= pid;
          len_zero <= (len_c == '0);
          rd_left  <= len_c;
          tx_left  <= len_c;
          busy     <= 1'b1;
          state    <= PID;
        end
        PID: begin
          if (!tx_valid) begin
            tx_data  <= {~pid_q, pid_q};
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (len_zero) begin
              tx_data <= ~crc_q[7:0];
              state   <= CRC_LO;
            end else begin
              tx_valid <= avail;
              if (avail) tx_data <= head;
              state <= DATA;
            end
          end
        end
        DATA: if (ld) begin
          if (fire && last_data) begin
            tx_data  <= ~crc_next[7:0];
            tx_valid <= 1'b1;
            state    <= CRC_LO;
          end else begin
            tx_valid <= avail;
            if (avail) tx_data <= head;
          end
          if (fire) tx_left <= tx_left - LEN_ONE;
        end
        CRC_LO: if (tx_ready) begin
          tx_data <= ~crc_q[15:8];
          tx_last <= 1'b1;
          state   <= CRC_HI;
        end
        CRC_HI: if (tx_ready) begin
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
